// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I micro-op encoder with legality check, encode register stage and output FIFO
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic [4:0]  inOp,
    input  logic [4:0]  inRd,
    input  logic [4:0]  inRs1,
    input  logic [4:0]  inRs2,
    input  logic [31:0] inImm,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInstr,
    output logic        err,
    output logic [7:0]  errCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic signed [31:0] simm;
    logic               imm12_ok;
    logic               shamt_ok;
    logic               branch_ok;
    logic               jal_ok;
    logic [31:0]        enc_word;
    logic               enc_legal;

    logic               stage_valid;
    logic               stage_legal;
    logic [31:0]        stage_word;
    logic               stage_drain;
    logic               in_fire;

    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [AW:0]        count;
    logic               full;
    logic               push;
    logic               pop;

    assign simm      = inImm;
    assign imm12_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign shamt_ok  = (simm >= 32'sd0) && (simm <= 32'sd31);
    assign branch_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !inImm[0];
    assign jal_ok    = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !inImm[0];

    // Pack the request into an RV32I word and flag out-of-range immediates or unknown ops
    always_comb begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b1;
        case (inOp)
            5'd0:  enc_word = {F7_BASE, inRs2, inRs1, 3'b000, inRd, OPC_OP};
            5'd1:  enc_word = {F7_ALT,  inRs2, inRs1, 3'b000, inRd, OPC_OP};
            5'd2:  enc_word = {F7_BASE, inRs2, inRs1, 3'b100, inRd, OPC_OP};
            5'd3:  enc_word = {F7_BASE, inRs2, inRs1, 3'b110, inRd, OPC_OP};
            5'd4:  enc_word = {F7_BASE, inRs2, inRs1, 3'b111, inRd, OPC_OP};
            5'd5:  enc_word = {F7_BASE, inRs2, inRs1, 3'b001, inRd, OPC_OP};
            5'd6:  enc_word = {F7_BASE, inRs2, inRs1, 3'b101, inRd, OPC_OP};
            5'd7:  enc_word = {F7_ALT,  inRs2, inRs1, 3'b101, inRd, OPC_OP};
            5'd8:  begin enc_word = {inImm[11:0], inRs1, 3'b000, inRd, OPC_IMM}; enc_legal = imm12_ok; end
            5'd9:  begin enc_word = {inImm[11:0], inRs1, 3'b100, inRd, OPC_IMM}; enc_legal = imm12_ok; end
            5'd10: begin enc_word = {inImm[11:0], inRs1, 3'b110, inRd, OPC_IMM}; enc_legal = imm12_ok; end
            5'd11: begin enc_word = {inImm[11:0], inRs1, 3'b111, inRd, OPC_IMM}; enc_legal = imm12_ok; end
            5'd12: begin enc_word = {F7_BASE, inImm[4:0], inRs1, 3'b001, inRd, OPC_IMM}; enc_legal = shamt_ok; end
            5'd13: begin enc_word = {F7_BASE, inImm[4:0], inRs1, 3'b101, inRd, OPC_IMM}; enc_legal = shamt_ok; end
            5'd14: begin enc_word = {F7_ALT,  inImm[4:0], inRs1, 3'b101, inRd, OPC_IMM}; enc_legal = shamt_ok; end
            5'd15: begin enc_word = {inImm[11:0], inRs1, 3'b010, inRd, OPC_LOAD}; enc_legal = imm12_ok; end
            5'd16: begin
                enc_word  = {inImm[11:5], inRs2, inRs1, 3'b010, inImm[4:0], OPC_STORE};
                enc_legal = imm12_ok;
            end
            5'd17: begin
                enc_word  = {inImm[12], inImm[10:5], inRs2, inRs1, 3'b000, inImm[4:1], inImm[11], OPC_BRANCH};
                enc_legal = branch_ok;
            end
            5'd18: begin
                enc_word  = {inImm[12], inImm[10:5], inRs2, inRs1, 3'b001, inImm[4:1], inImm[11], OPC_BRANCH};
                enc_legal = branch_ok;
            end
            5'd19: begin
                enc_word  = {inImm[12], inImm[10:5], inRs2, inRs1, 3'b100, inImm[4:1], inImm[11], OPC_BRANCH};
                enc_legal = branch_ok;
            end
            5'd20: begin
                enc_word  = {inImm[12], inImm[10:5], inRs2, inRs1, 3'b101, inImm[4:1], inImm[11], OPC_BRANCH};
                enc_legal = branch_ok;
            end
            5'd21: begin
                enc_word  = {inImm[20], inImm[10:1], inImm[11], inImm[19:12], inRd, OPC_JAL};
                enc_legal = jal_ok;
            end
            5'd22: begin enc_word = {inImm[11:0], inRs1, 3'b000, inRd, OPC_JALR}; enc_legal = imm12_ok; end
            5'd23: enc_word = NOP_WORD;
            default: begin enc_word = 32'h0; enc_legal = 1'b0; end
        endcase
    end

    // A popping consumer frees a slot in the same cycle, so a full FIFO can still take the stage word
    assign full        = (count == FULL_COUNT);
    assign pop         = outValid && outReady;
    assign push        = stage_valid && stage_legal && (!full || pop);
    assign stage_drain = stage_valid && (!stage_legal || !full || pop);
    assign inReady     = !stage_valid || stage_drain;
    assign in_fire     = inValid && inReady;
    assign err         = stage_valid && !stage_legal;

    // Encode stage: capture a new request, or empty once the word has moved on or been dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_legal <= 1'b0;
            stage_word  <= 32'h0;
        end else if (in_fire) begin
            stage_valid <= 1'b1;
            stage_legal <= enc_legal;
            stage_word  <= enc_word;
        end else if (stage_drain) begin
            stage_valid <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset since outInstr is masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= stage_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Saturating tally of dropped illegal requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCount <= 8'h00;
        end else if (err && (errCount != 8'hFF)) begin
            errCount <= errCount + 8'h01;
        end
    end

    assign outValid = (count != '0);
    assign outInstr = outValid ? mem[rptr] : 32'h0;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven scoreboard bench for instr_encoder
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inOp;
    logic [4:0]  inRd;
    logic [4:0]  inRs1;
    logic [4:0]  inRs2;
    logic [31:0] inImm;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic        err;
    logic [7:0]  errCount;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .inOp     (inOp),
        .inRd     (inRd),
        .inRs1    (inRs1),
        .inRs2    (inRs2),
        .inImm    (inImm),
        .outValid (outValid),
        .outReady (outReady),
        .outInstr (outInstr),
        .err      (err),
        .errCount (errCount)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_pulses = 0;
    int          exp_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
        end
    endtask

    task automatic v(input int op, input int rd, input int rs1, input int rs2, input int imm,
                     input bit legal, input logic [31:0] word);
        vec_t e;
        e.op = 5'(op); e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
        e.imm = 32'(imm); e.legal = legal; e.word = word;
        vt.push_back(e);
    endtask

    // Output monitor: compare every transfer against the scoreboard, count err pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_pulses++;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%08h want none", outInstr);
                end else begin
                    check("out_word", outInstr, exp_q.pop_front());
                end
            end
        end
    end

    // Drive one request, wait for acceptance, then record the expected word
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit legal,
                        input logic [31:0] word);
        int t;
        inOp = op; inRd = rd; inRs1 = rs1; inRs2 = rs2; inImm = imm;
        inValid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (inReady) break;
            t++;
            if (t > 100) break;
        end
        if (t > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got inReady=0 want 1");
        end
        @(posedge clk);
        if (t <= 100 && legal) exp_q.push_back(word);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        err_pulses = 0;
    endtask

    initial begin
        rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inOp = '0; inRd = '0; inRs1 = '0; inRs2 = '0; inImm = '0;

        // legal vectors
        v(0, 3, 1, 2, 0, 1, 32'h002081B3);     // ADD
        v(8, 1, 0, 9, -1, 1, 32'hFFF00093);    // ADDI -1
        v(16, 9, 1, 2, 8, 1, 32'h0020A423);    // SW, rd ignored
        v(17, 9, 1, 2, 8, 1, 32'h00208463);    // BEQ
        v(21, 1, 7, 7, 4, 1, 32'h004000EF);    // JAL
        v(14, 5, 5, 0, 3, 1, 32'h4032D293);    // SRAI
        v(23, 7, 3, 4, 99, 1, 32'h00000013);   // NOP ignores fields
        v(1, 3, 1, 2, 0, 1, 32'h402081B3);     // SUB
        v(2, 3, 1, 2, 0, 1, 32'h0020C1B3);     // XOR
        v(3, 3, 1, 2, 0, 1, 32'h0020E1B3);     // OR
        v(4, 3, 1, 2, 0, 1, 32'h0020F1B3);     // AND
        v(5, 3, 1, 2, 0, 1, 32'h002091B3);     // SLL
        v(6, 3, 1, 2, 0, 1, 32'h0020D1B3);     // SRL
        v(7, 3, 1, 2, 0, 1, 32'h4020D1B3);     // SRA
        v(8, 1, 2, 0, 2047, 1, 32'h7FF10093);  // ADDI max
        v(8, 1, 0, 0, -2048, 1, 32'h80000093); // ADDI min
        v(9, 1, 2, 0, 5, 1, 32'h00514093);     // XORI
        v(10, 1, 2, 0, 5, 1, 32'h00516093);    // ORI
        v(11, 1, 2, 0, 5, 1, 32'h00517093);    // ANDI
        v(12, 5, 5, 0, 31, 1, 32'h01F29293);   // SLLI max shamt
        v(13, 5, 5, 0, 0, 1, 32'h0002D293);    // SRLI shamt 0
        v(15, 1, 2, 0, 4, 1, 32'h00412083);    // LW
        v(16, 0, 1, 2, -1, 1, 32'hFE20AFA3);   // SW -1
        v(18, 0, 1, 2, -4, 1, 32'hFE209EE3);   // BNE -4
        v(19, 0, 1, 2, 4094, 1, 32'h7E20CFE3); // BLT max
        v(20, 0, 1, 2, -4096, 1, 32'h8020D063);// BGE min
        v(21, 0, 0, 0, -1048576, 1, 32'h8000006F); // JAL min
        v(21, 1, 0, 0, 1048574, 1, 32'h7FFFF0EF);  // JAL max
        v(22, 1, 2, 0, -8, 1, 32'hFF8100E7);   // JALR
        // illegal vectors
        v(8, 1, 0, 0, 2048, 0, 32'h0);
        v(8, 1, 0, 0, -2049, 0, 32'h0);
        v(17, 0, 1, 2, 7, 0, 32'h0);
        v(17, 0, 1, 2, 4096, 0, 32'h0);
        v(12, 1, 1, 0, 32, 0, 32'h0);
        v(14, 1, 1, 0, -1, 0, 32'h0);
        v(21, 1, 0, 0, 3, 0, 32'h0);
        v(21, 1, 0, 0, 1048576, 0, 32'h0);
        v(15, 1, 0, 0, 2048, 0, 32'h0);
        v(25, 1, 1, 1, 0, 0, 32'h0);
        v(31, 1, 1, 1, 0, 0, 32'h0);

        // reset state, asserted and after release
        #2;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outInstr", outInstr, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errCount", 32'(errCount), 32'd0);
        do_reset();
        check("rst_inReady", 32'(inReady), 32'd1);

        // latency: accept in N, word visible in N+2
        outReady = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        @(negedge clk);
        check("lat_n1_outValid", 32'(outValid), 32'd0);
        @(negedge clk);
        check("lat_n2_outValid", 32'(outValid), 32'd1);
        check("lat_n2_word", outInstr, 32'h002081B3);
        drain("lat_drain");

        // three illegal requests from a clean reset
        do_reset();
        send(5'd8, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
        send(5'd17, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h0);
        send(5'd25, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("ill3_errCount", 32'(errCount), 32'd3);
        check("ill3_pulses", 32'(err_pulses), 32'd3);
        check("ill3_outValid", 32'(outValid), 32'd0);

        // table sweep, back to back
        do_reset();
        exp_err = 0;
        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].legal, vt[i].word);
            if (!vt[i].legal) exp_err++;
        end
        drain("table_drain");
        check("table_pulses", 32'(err_pulses), 32'(exp_err));
        check("table_errCount", 32'(errCount), 32'(exp_err));

        // full FIFO backpressure, then push+pop while full
        do_reset();
        outReady = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(5'd8, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b1,
                 (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13);
        end
        inOp = 5'd8; inRd = 5'(DEPTH + 2); inRs1 = '0; inRs2 = '0; inImm = 32'(DEPTH + 1);
        inValid = 1'b1;
        @(negedge clk);
        check("full_inReady", 32'(inReady), 32'd0);
        check("full_head", outInstr, 32'h00000093);
        @(negedge clk);
        check("full_hold_inReady", 32'(inReady), 32'd0);
        check("full_head_stable", outInstr, 32'h00000093);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(negedge clk);
        check("pushpop_inReady", 32'(inReady), 32'd1);
        @(posedge clk);
        exp_q.push_back((32'(DEPTH + 1) << 20) | (32'(DEPTH + 2) << 7) | 32'h13);
        #1;
        outReady = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        check("pushpop_still_full", 32'(inReady), 32'd0);
        check("pushpop_new_head", outInstr, 32'h00100113);
        outReady = 1'b1;
        drain("full_drain");

        // saturation of errCount
        for (int i = 0; i < 260; i++) begin
            send(5'd30, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
        end
        repeat (3) @(negedge clk);
        check("sat_errCount", 32'(errCount), 32'd255);

        // reset mid-stream drops in-flight words and clears the tally at once
        outReady = 1'b0;
        send(5'd8, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 32'h00100093);
        send(5'd8, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1, 32'h00200113);
        @(negedge clk);
        check("mid_pre_outValid", 32'(outValid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_outValid", 32'(outValid), 32'd0);
        check("mid_errCount", 32'(errCount), 32'd0);
        check("mid_inReady", 32'(inReady), 32'd1);
        check("mid_outInstr", outInstr, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        send(5'd23, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 32'h00000013);
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
